idct_out_serializer: RTL and testbench
======================================

IDCT_OUT_SERIALIZER -- requirements
Module: idct_out_serializer

Interface
REQ-001 SHALL have parameter LATENCY, default 29, meaning the IDCT pipeline depth in clock cycles from input application to valid output.
REQ-002 SHALL have parameter WIDTH, default 16, meaning the signed sample width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: pulse in the cycle a block is applied to the IDCT inputs.
REQ-006 SHALL have ports in0..in63, input, WIDTH each, signed: the IDCT parallel outputs.
REQ-007 SHALL have port out_data, output, WIDTH, signed: the current stream sample.
REQ-008 SHALL have port out_valid, output, 1: out_data is valid.
REQ-009 SHALL have port out_ready, input, 1: the sink accepts a beat.
REQ-010 SHALL have port out_last, output, 1: the current beat is beat 63 of the block.
REQ-011 SHALL have port busy, output, 1: high in STREAM state.
REQ-012 SHALL have port overrun, output, 1: sticky flag set when a completed block is dropped.

Function
REQ-013 SHALL track in-flight blocks with a LATENCY-deep token shift register fed by start; multiple starts in consecutive cycles are permitted.
REQ-014 SHALL treat a token that emerges exactly LATENCY rising edges after start was sampled high as a capture request; in0..in63 are sampled on that edge.
REQ-015 SHALL implement two states: IDLE (buffer empty) and STREAM (buffer holds 64 samples, beat index 0..63).
REQ-016 IDLE -> STREAM on a capture request; the beat index is set to 0, and out_valid goes high in the following cycle.
REQ-017 A beat transfers when out_valid and out_ready are both high on a rising edge; the beat index then increments.
REQ-018 out_data and out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-019 After beat 63 transfers: with no simultaneous capture request, go STREAM -> IDLE; with a simultaneous capture request, capture the new block and restart at beat 0, with no idle cycle.
REQ-020 A capture request in STREAM without the final handshake SHALL drop the new block, set overrun, and leave the current stream undisturbed.
REQ-021 out_last SHALL equal (out_valid and beat index == 63).
REQ-022 out_data SHALL be a pure select of the captured buffer, with no arithmetic and no width change.
REQ-023 out_ready SHALL be ignored in IDCT_SER IDLE; out_valid SHALL never depend combinationally on out_ready.

Reset
REQ-024 Asserting rst at any time SHALL asynchronously clear the token register, state (IDLE), beat index, out_valid, out_last, busy and overrun; out_data SHALL reset to 0.
REQ-025 Reset mid-stream SHALL discard the partial block and all in-flight tokens; no beat is emitted until a new start plus LATENCY cycles.
REQ-026 overrun SHALL clear only on reset.

Configuration
REQ-027 With macro IDCT_SER_ZIGZAG_EN defined, beat k SHALL output buffer[ZZ[k]], where ZZ is the standard 8x8 zigzag scan (0,1,8,16,9,2,3,10,17,24,...,63).
REQ-028 Without IDCT_SER_ZIGZAG_EN, beat k SHALL output buffer[k] (raster order).

Verification
REQ-029 Raster order with LATENCY=29, in0..in3 = 21,-10,-26,-61 held, single start, out_ready=1: out_valid rises 30 cycles after start; beats 0..3 = 21,-10,-26,-61; 64 beats; out_last only on beat 63 (in63 = -37).
REQ-030 Backpressure with out_ready toggling 1,0,0,1 and the same block: every value is emitted exactly once, in order, and out_data is stable during the stall cycles.
REQ-031 Back-to-back blocks with starts 64 cycles apart and out_ready=1: the second block's beat 0 follows the first block's beat 63 with no gap; overrun=0.
REQ-032 Overrun with starts 10 cycles apart and out_ready=1: overrun=1 from the second capture edge; the first block streams all 64 beats intact; the second block is not emitted.
REQ-033 Reset mid-stream with rst pulsed at beat 20: out_valid=0, busy=0, overrun=0 immediately after reset; no further beats until a new start.
REQ-034 Zigzag order with IDCT_SER_ZIGZAG_EN defined and inK = K: beats 0..5 = 0,1,8,16,9,2; beat 63 = 63.

Source files
------------

// File: rtl/idct_out_serializer.sv
// idct_out_serializer: converts the 64 parallel IDCT outputs into a
// valid/ready sample stream, one block at a time.
// A start token rides a LATENCY-deep shift register. When it emerges, the
// block present on in0..in63 is captured and streamed as 64 beats.
// A block that completes while another is still streaming is dropped and
// flagged on the sticky overrun output.
// Optional feature: define IDCT_SER_ZIGZAG_EN to emit beats in 8x8 zigzag
// scan order. The default build emits them in raster order.
module idct_out_serializer #(
  parameter int LATENCY = 29,
  parameter int WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7,
  input  logic signed [WIDTH-1:0] in8,  in9,  in10, in11, in12, in13, in14, in15,
  input  logic signed [WIDTH-1:0] in16, in17, in18, in19, in20, in21, in22, in23,
  input  logic signed [WIDTH-1:0] in24, in25, in26, in27, in28, in29, in30, in31,
  input  logic signed [WIDTH-1:0] in32, in33, in34, in35, in36, in37, in38, in39,
  input  logic signed [WIDTH-1:0] in40, in41, in42, in43, in44, in45, in46, in47,
  input  logic signed [WIDTH-1:0] in48, in49, in50, in51, in52, in53, in54, in55,
  input  logic signed [WIDTH-1:0] in56, in57, in58, in59, in60, in61, in62, in63,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

`ifdef IDCT_SER_ZIGZAG_EN
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
`endif

  // Maps a beat number to the buffer slot that beat emits.
  function automatic logic [5:0] scan(input logic [5:0] k);
`ifdef IDCT_SER_ZIGZAG_EN
    return ZZ[k];
`else
    return k;
`endif
  endfunction

  logic signed [WIDTH-1:0] in_arr [64];
  logic signed [WIDTH-1:0] mem_q  [64];
  logic [LATENCY-1:0]      tok_q;
  state_t                  state_q;
  logic [5:0]              idx_q;
  logic signed [WIDTH-1:0] data_q;
  logic                    valid_q, last_q, busy_q, overrun_q;
  logic                    cap_req, fire, last_fire, capture;

  assign in_arr = '{
    in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7,
    in8,  in9,  in10, in11, in12, in13, in14, in15,
    in16, in17, in18, in19, in20, in21, in22, in23,
    in24, in25, in26, in27, in28, in29, in30, in31,
    in32, in33, in34, in35, in36, in37, in38, in39,
    in40, in41, in42, in43, in44, in45, in46, in47,
    in48, in49, in50, in51, in52, in53, in54, in55,
    in56, in57, in58, in59, in60, in61, in62, in63};

  // A capture is accepted when idle, or when the final beat leaves on the
  // same edge, so back-to-back blocks stream without a bubble.
  assign cap_req   = tok_q[LATENCY-1];
  assign fire      = valid_q & out_ready;
  assign last_fire = fire && (idx_q == 6'd63);
  assign capture   = cap_req && ((state_q == IDLE) || last_fire);

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

  // Token pipeline that mirrors the IDCT depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_q <= '0;
    end else begin
      tok_q[0] <= start;
      for (int i = 1; i < LATENCY; i++) tok_q[i] <= tok_q[i-1];
    end
  end

  // Block buffer; holds pure data, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) mem_q <= in_arr;
  end

  // Stream FSM with registered valid/last/busy/data and the sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 6'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      if (cap_req && !capture) overrun_q <= 1'b1;
      if (capture) begin
        state_q <= STREAM;
        idx_q   <= 6'd0;
        valid_q <= 1'b1;
        last_q  <= 1'b0;
        busy_q  <= 1'b1;
        data_q  <= in_arr[scan(6'd0)];
      end else if (last_fire) begin
        state_q <= IDLE;
        idx_q   <= 6'd0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else if (fire) begin
        idx_q  <= idx_q + 6'd1;
        last_q <= (idx_q == 6'd62);
        data_q <= mem_q[scan(idx_q + 6'd1)];
      end
    end
  end

endmodule

// File: tb/tb_idct_out_serializer.sv
// Bench for idct_out_serializer: a queue-based reference model of the
// expected beat stream, a per-cycle compare process, directed scenarios
// with literal expectations, and a randomized phase.
module tb_idct_out_serializer;
  localparam int LAT = 29;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic signed [W-1:0] din [64];
  logic signed [W-1:0] out_data;
  logic out_valid, out_last, busy, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idct_out_serializer #(.LATENCY(LAT), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in0(din[0]),   .in1(din[1]),   .in2(din[2]),   .in3(din[3]),   .in4(din[4]),   .in5(din[5]),   .in6(din[6]),   .in7(din[7]),
    .in8(din[8]),   .in9(din[9]),   .in10(din[10]), .in11(din[11]), .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
    .in16(din[16]), .in17(din[17]), .in18(din[18]), .in19(din[19]), .in20(din[20]), .in21(din[21]), .in22(din[22]), .in23(din[23]),
    .in24(din[24]), .in25(din[25]), .in26(din[26]), .in27(din[27]), .in28(din[28]), .in29(din[29]), .in30(din[30]), .in31(din[31]),
    .in32(din[32]), .in33(din[33]), .in34(din[34]), .in35(din[35]), .in36(din[36]), .in37(din[37]), .in38(din[38]), .in39(din[39]),
    .in40(din[40]), .in41(din[41]), .in42(din[42]), .in43(din[43]), .in44(din[44]), .in45(din[45]), .in46(din[46]), .in47(din[47]),
    .in48(din[48]), .in49(din[49]), .in50(din[50]), .in51(din[51]), .in52(din[52]), .in53(din[53]), .in54(din[54]), .in55(din[55]),
    .in56(din[56]), .in57(din[57]), .in58(din[58]), .in59(din[59]), .in60(din[60]), .in61(din[61]), .in62(din[62]), .in63(din[63]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun));

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Zigzag position k, generated by walking the anti-diagonals of an 8x8 grid.
  function automatic int zz(input int k);
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      for (int t = 0; t <= hi - lo; t++) begin
        int r = (s % 2 == 0) ? hi - t : lo + t;
        if (n == k) return r * 8 + (s - r);
        n++;
      end
    end
    return 0;
  endfunction

  function automatic int ord(input int k);
`ifdef IDCT_SER_ZIGZAG_EN
    return zz(k);
`else
    return k;
`endif
  endfunction

  // Reference model: queue of beats still to be delivered plus pending capture edges.
  int edge_n = 0;
  int due_q[$];
  int exp_q[$];
  bit ovr_m = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      due_q.delete();
      exp_q.delete();
      ovr_m = 1'b0;
    end else begin
      bit cap;
      cap = (due_q.size() > 0) && (due_q[0] == edge_n);
      if (cap) void'(due_q.pop_front());
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (cap) begin
        if (exp_q.size() == 0) begin
          for (int k = 0; k < 64; k++) exp_q.push_back(int'(din[ord(k)]));
        end else begin
          ovr_m = 1'b1;
        end
      end
      if (start) due_q.push_back(edge_n + LAT);
      edge_n++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", int'(out_valid), int'(exp_q.size() != 0));
      check("busy", int'(busy), int'(exp_q.size() != 0));
      check("overrun", int'(overrun), int'(ovr_m));
      check("last", int'(out_last), int'(exp_q.size() == 1));
      if (exp_q.size() != 0) check("data", int'(out_data), exp_q[0]);
    end
  end

  int lit[$];
  int lit63;
  int beats[64];
  int lastpos, lastcnt, lat, n, cnt, first, lastc, ovr_first;
  bit got, prev_v, prev_r;
  int prev_d;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
`ifdef IDCT_SER_ZIGZAG_EN
    for (int k = 0; k < 64; k++) din[k] = 16'(k);
    lit = '{0, 1, 8, 16, 9, 2};
    lit63 = 63;
`else
    for (int k = 0; k < 64; k++) din[k] = 16'($urandom);
    din[0] = 16'sd21; din[1] = -16'sd10; din[2] = -16'sd26; din[3] = -16'sd61; din[63] = -16'sd37;
    lit = '{21, -10, -26, -61};
    lit63 = -37;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_last", int'(out_last), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single block, sink always ready: latency and literal beats.
    start = 1'b1; got = 0; lat = 0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin got = 1; lat = c; end
    end
    check("latency", lat, 30);
    lastcnt = 0; lastpos = -1;
    for (int b = 0; b < 64; b++) begin
      if (b > 0) @(negedge clk);
      beats[b] = int'(out_data);
      if (out_last) begin lastcnt++; lastpos = b; end
    end
    for (int i = 0; i < lit.size(); i++) check($sformatf("lit_beat%0d", i), beats[i], lit[i]);
    check("lit_beat63", beats[63], lit63);
    check("last_count", lastcnt, 1);
    check("last_pos", lastpos, 63);
    @(negedge clk);
    check("idle_after_block", int'(out_valid), 0);

    // Backpressure with ready pattern 1,0,0,1.
    start = 1'b1; n = 0; prev_v = 0; prev_r = 1; prev_d = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (prev_v && !prev_r) check("stall_stable", int'(out_data), prev_d);
      out_ready = pat[c % 4];
      if (out_valid && out_ready) begin
        if (n < 64) check("bp_beat", int'(out_data), int'(din[ord(n)]));
        n++;
      end
      prev_v = out_valid; prev_r = out_ready; prev_d = int'(out_data);
    end
    check("bp_count", n, 64);
    out_ready = 1'b1;

    // Back-to-back blocks 64 cycles apart: no gap between them.
    cnt = 0; first = -1; lastc = -1;
    for (int c = 0; c < 300; c++) begin
      start = (c == 0 || c == 64);
      @(negedge clk);
      if (out_valid) begin cnt++; if (first < 0) first = c; lastc = c; end
    end
    start = 1'b0;
    check("b2b_count", cnt, 128);
    check("b2b_span", lastc - first + 1, 128);
    check("b2b_overrun", int'(overrun), 0);

    // Overrun: second start 10 cycles after the first.
    cnt = 0; ovr_first = -1;
    for (int c = 0; c < 300; c++) begin
      start = (c == 0 || c == 10);
      @(negedge clk);
      if (out_valid) cnt++;
      if (overrun && ovr_first < 0) ovr_first = c;
    end
    start = 1'b0;
    check("ovr_count", cnt, 64);
    check("ovr_edge", ovr_first, 39);
    check("ovr_sticky", int'(overrun), 1);

    // Reset at beat 20 of a stream.
    start = 1'b1; got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) got = 1;
    end
    check("rst_test_started", int'(got), 1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    check("mid_rst_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("no_beats_after_rst", cnt, 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 1499) == 0) rst = 1'b1;
      start = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 64; k++) din[k] = 16'($urandom);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
